// File: rtl/sky130_fd_io__pwrgood_pkg.sv
// Shared types and constants for the power-good sequencer.
package sky130_fd_io__pwrgood_pkg;

    // Sequencer counter width and glitch-counter width/saturation value.
    localparam int CNT_W = 16;
    localparam int GC_W  = 8;
    localparam logic [GC_W-1:0] GC_MAX = 8'd255;

    // Sequencer states; encodings 5-7 are illegal and fall back to OFF.
    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_DEB  = 3'd1,
        ST_HVUP = 3'd2,
        ST_GOOD = 3'd3,
        ST_DOWN = 3'd4
    } state_t;

    // Next glitch count: a clear wins over history, but an abort on the
    // same edge still counts once; otherwise saturating increment.
    function automatic logic [GC_W-1:0] gc_next(input logic [GC_W-1:0] cur,
                                                input logic            inc,
                                                input logic            clr);
        if (clr)
            return inc ? GC_W'(1) : '0;
        if (inc && (cur != GC_MAX))
            return cur + 1'b1;
        return cur;
    endfunction

endpackage

// File: rtl/sky130_fd_io__sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sky130_fd_io__sync2 (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the raw level through two flops; both clear on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/sky130_fd_io__pwrgood_seq.sv
// Power-good sequencer: debounces the pad supply-valid level, then brings
// up the HV domain before the LV domain, and tears them down in reverse.
module sky130_fd_io__pwrgood_seq
    import sky130_fd_io__pwrgood_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned SEQ_CYCLES = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            VALID_RAW,
    input  logic            CLR_GLITCH,
    output logic            EN_HV,
    output logic            EN_LV,
    output logic            PWRGOOD,
    output logic [GC_W-1:0] GLITCH_CNT,
    output logic [2:0]      STATE
);

    localparam logic [CNT_W-1:0] LP_DEB = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] LP_SEQ = CNT_W'(SEQ_CYCLES);

    logic             w_vs;
    logic             w_abort;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_en_hv;
    logic             r_en_lv;
    logic             r_pg;
    logic [GC_W-1:0]  r_gc;

    // VALID_RAW is only ever seen through this synchronizer.
    sky130_fd_io__sync2 u_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (VALID_RAW),
        .o_q   (w_vs)
    );

    // Counter stays below its terminal value in every state, so +1 never wraps.
    assign w_cnt_inc = r_cnt + 1'b1;

    // An abort is losing valid before the LV domain was ever enabled.
    assign w_abort = ((r_state == ST_DEB) || (r_state == ST_HVUP)) && !w_vs;

    // Sequencer FSM with registered enables.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_en_hv <= 1'b0;
            r_en_lv <= 1'b0;
            r_pg    <= 1'b0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    r_en_hv <= 1'b0;
                    r_en_lv <= 1'b0;
                    r_pg    <= 1'b0;
                    if (w_vs) begin
                        r_state <= ST_DEB;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                ST_DEB: begin
                    // r_cnt holds the number of valid edges already seen.
                    if (!w_vs) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_en_hv <= 1'b0;
                    end else if (r_cnt >= LP_DEB) begin
                        r_state <= ST_HVUP;
                        r_cnt   <= '0;
                        r_en_hv <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_HVUP: begin
                    if (!w_vs) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_en_hv <= 1'b0;
                    end else if (w_cnt_inc == LP_SEQ) begin
                        r_state <= ST_GOOD;
                        r_cnt   <= '0;
                        r_en_lv <= 1'b1;
                        r_pg    <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_GOOD: begin
                    r_en_hv <= 1'b1;
                    if (!w_vs) begin
                        r_state <= ST_DOWN;
                        r_cnt   <= '0;
                        r_en_lv <= 1'b0;
                        r_pg    <= 1'b0;
                    end
                end
                ST_DOWN: begin
                    // Power-down always runs to completion; V_S is ignored.
                    r_en_lv <= 1'b0;
                    r_pg    <= 1'b0;
                    if (w_cnt_inc == LP_SEQ) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_en_hv <= 1'b0;
                    end else begin
                        r_cnt   <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_OFF;
                    r_cnt   <= '0;
                    r_en_hv <= 1'b0;
                    r_en_lv <= 1'b0;
                    r_pg    <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of aborted power-ups, with synchronous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_gc <= '0;
        else
            r_gc <= gc_next(r_gc, w_abort, CLR_GLITCH);
    end

    assign EN_HV      = r_en_hv;
    assign EN_LV      = r_en_lv;
    assign PWRGOOD    = r_pg;
    assign GLITCH_CNT = r_gc;
    assign STATE      = r_state;

endmodule
